// File: rtl/red_pitaya_asg_seq_pkg.sv
// red_pitaya_asg_seq_pkg
//   Shared types for the ASG segment sequencer: FSM state encoding, the
//   segment table entry layout and the microsecond tick divider.
//   Optional feature macro: ASG_SEQ_DWELL_EN (adds the DWELL state and a
//   per-entry dwell field).
package red_pitaya_asg_seq_pkg;

   // 125 MHz DAC clock -> 1 us tick
   localparam int TICK_DIV = 125;

   // Pointer width for the default buffer (RSZ=14 plus 16 fractional bits)
   localparam int PTR_W = 30;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ARM,
      ST_RUN,
`ifdef ASG_SEQ_DWELL_EN
      ST_DWELL,
`endif
      ST_NEXT
   } seq_state_t;

   typedef struct packed {
      logic [PTR_W-1:0] ofs;
      logic [PTR_W-1:0] size;
      logic [PTR_W-1:0] step;
      logic [15:0]      npass;
`ifdef ASG_SEQ_DWELL_EN
      logic [15:0]      dwell;
`endif
   } seg_entry_t;

   // A pass count of 0 behaves as a single pass
   function automatic logic [15:0] npass_eff(input logic [15:0] n);
      return (n == 16'd0) ? 16'd1 : n;
   endfunction

endpackage

// File: rtl/red_pitaya_asg_seq_tbl.sv
// red_pitaya_asg_seq_tbl
//   NSEG-entry segment table. One write port, one registered read port.
//   All entries and the read register clear on asynchronous reset.
//   Ports:
//     clk_i, rstn_i      clock, asynchronous active-low reset
//     we_i, waddr_i,     write strobe, entry index and full entry
//     wdata_i
//     re_i, raddr_i      read enable and index; read data updates on the
//                        edge where re_i is high
//     rdata_o            registered read data (holds while re_i is low)
//   The read path samples the array before the write lands, so a write on
//   the same edge as a read of that entry returns the old contents.
module red_pitaya_asg_seq_tbl
   import red_pitaya_asg_seq_pkg::*;
#(
   parameter int NSEG = 8,
   parameter int SW   = 3
)(
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          we_i,
   input  logic [SW-1:0] waddr_i,
   input  seg_entry_t    wdata_i,
   input  logic          re_i,
   input  logic [SW-1:0] raddr_i,
   output seg_entry_t    rdata_o
);

   seg_entry_t mem_q [NSEG];
   seg_entry_t mem_d [NSEG];
   seg_entry_t rd_q;
   seg_entry_t rd_d;

   always_comb begin
      mem_d = mem_q;
      if (we_i) begin
         mem_d[waddr_i] = wdata_i;
      end
      rd_d = rd_q;
      if (re_i) begin
         rd_d = mem_q[raddr_i];
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < NSEG; i++) begin
            mem_q[i] <= '0;
         end
         rd_q <= '0;
      end else begin
         mem_q <= mem_d;
         rd_q  <= rd_d;
      end
   end

   assign rdata_o = rd_q;

endmodule

// File: rtl/red_pitaya_asg_seq.sv
// red_pitaya_asg_seq
//   Segment sequencer for one ASG channel (dac_clk_i domain). Plays the
//   segments of a small table back to back: for each segment it loads the
//   channel configuration, releases the channel reset with a software
//   trigger, then counts channel end-of-table pulses until the segment's
//   pass count is reached.
//   Optional feature macro: ASG_SEQ_DWELL_EN -- adds tbl_dwell_i and a
//   DWELL state that holds the channel in reset for dwell x 1 us between
//   segments (using the dwell of the segment just finished).
//   Ports:
//     dac_clk_i, dac_rstn_i           clock, asynchronous active-low reset
//     tbl_we_i, tbl_seg_i, tbl_*_i    table write port (one full entry)
//     seq_len_i, seq_loop_i           active entries, loop enable
//     seq_start_i, seq_stop_i         start / abort pulses
//     ch_wrap_i                       channel end-of-table pulse
//     set_ofs_o/set_size_o/set_step_o channel configuration
//     set_rst_o, trig_sw_o            channel reset and software trigger
//     seq_busy_o, seq_seg_o,          status: busy, current entry,
//     seq_done_o                      natural-completion pulse
module red_pitaya_asg_seq
   import red_pitaya_asg_seq_pkg::*;
#(
   parameter int RSZ  = 14,
   parameter int NSEG = 8,
   parameter int SW   = 3
)(
   input  logic              dac_clk_i,
   input  logic              dac_rstn_i,
   input  logic              tbl_we_i,
   input  logic [SW-1:0]     tbl_seg_i,
   input  logic [RSZ+15:0]   tbl_ofs_i,
   input  logic [RSZ+15:0]   tbl_size_i,
   input  logic [RSZ+15:0]   tbl_step_i,
   input  logic [15:0]       tbl_npass_i,
`ifdef ASG_SEQ_DWELL_EN
   input  logic [15:0]       tbl_dwell_i,
`endif
   input  logic [SW:0]       seq_len_i,
   input  logic              seq_loop_i,
   input  logic              seq_start_i,
   input  logic              seq_stop_i,
   input  logic              ch_wrap_i,
   output logic [RSZ+15:0]   set_ofs_o,
   output logic [RSZ+15:0]   set_size_o,
   output logic [RSZ+15:0]   set_step_o,
   output logic              set_rst_o,
   output logic              trig_sw_o,
   output logic              seq_busy_o,
   output logic [SW-1:0]     seq_seg_o,
   output logic              seq_done_o
);

   localparam int PW = RSZ + 16;

   seq_state_t    state_q, state_d;
   logic [SW-1:0] seg_q, seg_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          set_rst_q, set_rst_d;
   logic          trig_q, trig_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
`ifdef ASG_SEQ_DWELL_EN
   logic [6:0]    tick_q, tick_d;
   logic [15:0]   us_q, us_d;
`endif

   logic [SW:0]   seg_nxt;
   logic          last_seg;
   logic          len_ok;
   logic          load_en;
   seg_entry_t    wr_entry;
   seg_entry_t    entry;

   always_comb begin
      wr_entry       = '0;
      wr_entry.ofs   = PTR_W'(tbl_ofs_i);
      wr_entry.size  = PTR_W'(tbl_size_i);
      wr_entry.step  = PTR_W'(tbl_step_i);
      wr_entry.npass = tbl_npass_i;
`ifdef ASG_SEQ_DWELL_EN
      wr_entry.dwell = tbl_dwell_i;
`endif
   end

   // The table read is enabled on the edge that enters LOAD, so the
   // configuration registers hold the entry as it was before that edge.
   red_pitaya_asg_seq_tbl #(
      .NSEG (NSEG),
      .SW   (SW)
   ) i_tbl (
      .clk_i   (dac_clk_i),
      .rstn_i  (dac_rstn_i),
      .we_i    (tbl_we_i),
      .waddr_i (tbl_seg_i),
      .wdata_i (wr_entry),
      .re_i    (load_en),
      .raddr_i (seg_d),
      .rdata_o (entry)
   );

   always_comb begin
      state_d = state_q;
      seg_d   = seg_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
`ifdef ASG_SEQ_DWELL_EN
      tick_d  = tick_q;
      us_d    = us_q;
`endif

      seg_nxt  = {1'b0, seg_q} + (SW+1)'(1);
      // A length raised past NSEG mid-run still ends at the last entry
      last_seg = (seg_nxt >= seq_len_i) || (seg_nxt == (SW+1)'(NSEG));
      len_ok   = (seq_len_i != '0) && (seq_len_i <= (SW+1)'(NSEG));

      if (seq_stop_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (seq_start_i && len_ok) begin
                  seg_d   = '0;
                  state_d = ST_LOAD;
               end
            end
            ST_LOAD: begin
               cnt_d   = '0;
               state_d = ST_ARM;
            end
            ST_ARM: begin
               state_d = ST_RUN;
            end
            ST_RUN: begin
               if (ch_wrap_i) begin
                  cnt_d = cnt_q + 16'd1;
                  if (cnt_d == npass_eff(entry.npass)) begin
                     state_d = ST_NEXT;
                  end
               end
            end
            ST_NEXT: begin
               if (!last_seg) begin
                  seg_d   = seg_nxt[SW-1:0];
                  state_d = ST_LOAD;
`ifdef ASG_SEQ_DWELL_EN
                  // entry still holds the segment that just finished
                  if (entry.dwell != 16'd0) begin
                     tick_d  = '0;
                     us_d    = '0;
                     state_d = ST_DWELL;
                  end
`endif
               end else if (seq_loop_i) begin
                  seg_d   = '0;
                  state_d = ST_LOAD;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
`ifdef ASG_SEQ_DWELL_EN
            ST_DWELL: begin
               if (tick_q == 7'(TICK_DIV - 1)) begin
                  tick_d = '0;
                  us_d   = us_q + 16'd1;
                  if (us_d == entry.dwell) begin
                     state_d = ST_LOAD;
                  end
               end else begin
                  tick_d = tick_q + 7'd1;
               end
            end
`endif
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Outputs are registered decodes of the next state
      load_en   = (state_d == ST_LOAD);
      set_rst_d = !((state_d == ST_ARM) || (state_d == ST_RUN));
      trig_d    = (state_d == ST_ARM);
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
      if (!dac_rstn_i) begin
         state_q   <= ST_IDLE;
         seg_q     <= '0;
         cnt_q     <= '0;
         set_rst_q <= 1'b1;
         trig_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef ASG_SEQ_DWELL_EN
         tick_q    <= '0;
         us_q      <= '0;
`endif
      end else begin
         state_q   <= state_d;
         seg_q     <= seg_d;
         cnt_q     <= cnt_d;
         set_rst_q <= set_rst_d;
         trig_q    <= trig_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef ASG_SEQ_DWELL_EN
         tick_q    <= tick_d;
         us_q      <= us_d;
`endif
      end
   end

   assign set_ofs_o  = PW'(entry.ofs);
   assign set_size_o = PW'(entry.size);
   assign set_step_o = PW'(entry.step);
   assign set_rst_o  = set_rst_q;
   assign trig_sw_o  = trig_q;
   assign seq_busy_o = busy_q;
   assign seq_seg_o  = seg_q;
   assign seq_done_o = done_q;

endmodule

// File: tb/tb_red_pitaya_asg_seq.sv
`timescale 1ns/1ps
module tb_red_pitaya_asg_seq;

   localparam int RSZ  = 14;
   localparam int NSEG = 8;
   localparam int SW   = 3;
   localparam int PW   = RSZ + 16;
`ifdef ASG_SEQ_DWELL_EN
   localparam bit DWELL_EN = 1'b1;
`else
   localparam bit DWELL_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic          tbl_we = 1'b0;
   logic [SW-1:0] tbl_seg = '0;
   logic [PW-1:0] tbl_ofs = '0, tbl_size = '0, tbl_step = '0;
   logic [15:0]   tbl_npass = '0;
`ifdef ASG_SEQ_DWELL_EN
   logic [15:0]   tbl_dwell = '0;
`endif
   logic [SW:0]   seq_len = '0;
   logic          seq_loop = 1'b0, seq_start = 1'b0, seq_stop = 1'b0;
   logic          ch_wrap = 1'b0;
   logic [PW-1:0] set_ofs, set_size, set_step;
   logic          set_rst, trig_sw, seq_busy, seq_done;
   logic [SW-1:0] seq_seg;

   red_pitaya_asg_seq #(.RSZ(RSZ), .NSEG(NSEG), .SW(SW)) dut (
      .dac_clk_i   (clk),
      .dac_rstn_i  (rstn),
      .tbl_we_i    (tbl_we),
      .tbl_seg_i   (tbl_seg),
      .tbl_ofs_i   (tbl_ofs),
      .tbl_size_i  (tbl_size),
      .tbl_step_i  (tbl_step),
      .tbl_npass_i (tbl_npass),
`ifdef ASG_SEQ_DWELL_EN
      .tbl_dwell_i (tbl_dwell),
`endif
      .seq_len_i   (seq_len),
      .seq_loop_i  (seq_loop),
      .seq_start_i (seq_start),
      .seq_stop_i  (seq_stop),
      .ch_wrap_i   (ch_wrap),
      .set_ofs_o   (set_ofs),
      .set_size_o  (set_size),
      .set_step_o  (set_step),
      .set_rst_o   (set_rst),
      .trig_sw_o   (trig_sw),
      .seq_busy_o  (seq_busy),
      .seq_seg_o   (seq_seg),
      .seq_done_o  (seq_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference table: what the channel should see when an entry is loaded
   logic [PW-1:0] m_ofs [NSEG];
   logic [PW-1:0] m_size[NSEG];
   logic [PW-1:0] m_step[NSEG];
   int            m_npass[NSEG];
   int            m_dwell[NSEG];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int passes(input int s);
      return (m_npass[s] == 0) ? 1 : m_npass[s];
   endfunction

   task automatic wr_entry(input int idx, input logic [PW-1:0] o, input logic [PW-1:0] sz,
                           input logic [PW-1:0] st, input int np, input int dw);
      tbl_we    = 1'b1;
      tbl_seg   = SW'(idx);
      tbl_ofs   = o;
      tbl_size  = sz;
      tbl_step  = st;
      tbl_npass = 16'(np);
`ifdef ASG_SEQ_DWELL_EN
      tbl_dwell = 16'(dw);
`endif
      tick();
      tbl_we = 1'b0;
      m_ofs[idx]   = o;
      m_size[idx]  = sz;
      m_step[idx]  = st;
      m_npass[idx] = np;
      m_dwell[idx] = DWELL_EN ? dw : 0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 64'(seq_busy), 64'd0);
      chk({tag, "_rst"},  64'(set_rst),  64'd1);
      chk({tag, "_trig"}, 64'(trig_sw),  64'd0);
   endtask

   // Entered right after the edge that moves the sequencer into LOAD
   task automatic load_arm(input int s);
      chk("load_rst",  64'(set_rst),  64'd1);
      chk("load_trig", 64'(trig_sw),  64'd0);
      chk("load_busy", 64'(seq_busy), 64'd1);
      chk("load_done", 64'(seq_done), 64'd0);
      chk("load_seg",  64'(seq_seg),  64'(s));
      chk("load_ofs",  64'(set_ofs),  64'(m_ofs[s]));
      chk("load_size", 64'(set_size), 64'(m_size[s]));
      chk("load_step", 64'(set_step), 64'(m_step[s]));
      ch_wrap = 1'($urandom_range(0, 1));   // must be ignored outside RUN
      tick();
      chk("arm_trig", 64'(trig_sw), 64'd1);
      chk("arm_rst",  64'(set_rst), 64'd0);
      chk("arm_ofs",  64'(set_ofs), 64'(m_ofs[s]));
      chk("arm_seg",  64'(seq_seg), 64'(s));
      ch_wrap = 1'($urandom_range(0, 1));
      tick();
      ch_wrap = 1'b0;
      chk("run_trig", 64'(trig_sw), 64'd0);
      chk("run_rst",  64'(set_rst), 64'd0);
   endtask

   // Delivers every pass of segment s; returns with the sequencer having
   // just consumed the final wrap
   task automatic play_passes(input int s);
      int n;
      n = passes(s);
      for (int p = 0; p < n; p++) begin
         repeat ($urandom_range(0, 2)) tick();
         ch_wrap = 1'b1;
         tick();
         ch_wrap = 1'b0;
         if (p < n - 1) begin
            tick();
            chk("pass_hold_rst",  64'(set_rst), 64'd0);
            chk("pass_hold_trig", 64'(trig_sw), 64'd0);
            chk("pass_hold_seg",  64'(seq_seg), 64'(s));
         end
      end
   endtask

   // Complete sequence from the start pulse. With loop set, nplay segments
   // are started and the last one is aborted with a stop pulse.
   task automatic run_seq(input int len, input bit loop, input int nplay);
      int s;
      int d;
      s = 0;
      seq_len   = (SW+1)'(len);
      seq_loop  = loop;
      seq_start = 1'b1;
      tick();
      seq_start = 1'b0;
      load_arm(0);
      for (int i = 0; i < nplay; i++) begin
         if (loop && (i == nplay - 1)) begin
            repeat ($urandom_range(0, 2)) tick();
            seq_stop = 1'b1;
            tick();
            seq_stop = 1'b0;
            chk_idle("stop");
            chk("stop_done", 64'(seq_done), 64'd0);
            tick();
            chk("stop_done2", 64'(seq_done), 64'd0);
            chk_idle("stop2");
            return;
         end
         play_passes(s);
         if (s + 1 < len) begin
            d = m_dwell[s] * 125;
            s++;
            tick();
            for (int k = 0; k < d; k++) begin
               chk("dwell_rst",  64'(set_rst), 64'd1);
               chk("dwell_trig", 64'(trig_sw), 64'd0);
               tick();
            end
            load_arm(s);
         end else if (loop) begin
            s = 0;
            tick();
            load_arm(0);
         end else begin
            tick();
            chk("done_pulse", 64'(seq_done), 64'd1);
            chk_idle("done");
            chk("done_seg", 64'(seq_seg), 64'(s));
            tick();
            chk("done_clear", 64'(seq_done), 64'd0);
            chk_idle("after_done");
            return;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < NSEG; i++) begin
         m_ofs[i] = '0; m_size[i] = '0; m_step[i] = '0; m_npass[i] = 0; m_dwell[i] = 0;
      end

      // Reset values
      #2 rstn = 1'b0;
      #1;
      chk_idle("reset");
      chk("reset_seg",  64'(seq_seg),  64'd0);
      chk("reset_done", 64'(seq_done), 64'd0);
      chk("reset_ofs",  64'(set_ofs),  64'd0);
      chk("reset_size", 64'(set_size), 64'd0);
      chk("reset_step", 64'(set_step), 64'd0);
      repeat (2) tick();
      rstn = 1'b1;
      tick();

      // Single entry, three passes, full-size table
      wr_entry(0, '0, 30'h3FFF_FFFF, 30'h0001_0000, 3, 0);
      run_seq(1, 1'b0, 1);

      // Three entries with pass counts 1, 2 and 0 (0 behaves as 1)
      wr_entry(0, 30'h0000_1000, 30'h0100_0000, 30'h0000_8000, 1, 0);
      wr_entry(1, 30'h0123_4000, 30'h0200_0000, 30'h0002_0000, 2, 0);
      wr_entry(2, 30'h0ABC_0000, 30'h3FFF_0000, 30'h0000_4000, 0, 0);
      run_seq(3, 1'b0, 3);

      // Start with stop, zero length and oversize length: no state change
      for (int v = 0; v < 3; v++) begin
         seq_len   = (v == 0) ? 4'd2 : ((v == 1) ? 4'd0 : 4'd9);
         seq_start = 1'b1;
         seq_stop  = (v == 0);
         tick();
         seq_start = 1'b0;
         seq_stop  = 1'b0;
         chk_idle("nostart");
         chk("nostart_seg", 64'(seq_seg), 64'd2);
         tick();
         chk_idle("nostart2");
      end

      // Looping two entries: entry 0 comes back, then stop aborts it
      run_seq(2, 1'b1, 3);

      // Start while busy is ignored
      wr_entry(0, 30'h0000_2222, 30'h0000_3333, 30'h0000_4444, 2, 0);
      seq_len   = 4'd1;
      seq_loop  = 1'b0;
      seq_start = 1'b1;
      tick();
      seq_start = 1'b0;
      load_arm(0);
      seq_start = 1'b1;
      tick();
      seq_start = 1'b0;
      chk("busy_start_rst",  64'(set_rst), 64'd0);
      chk("busy_start_trig", 64'(trig_sw), 64'd0);
      play_passes(0);
      tick();
      chk("busy_start_done", 64'(seq_done), 64'd1);

      // Rewrite entry 1 while entry 0 runs
      wr_entry(0, 30'h0000_0100, 30'h0000_0200, 30'h0000_0300, 1, 0);
      wr_entry(1, 30'h0000_0400, 30'h0000_0500, 30'h0000_0600, 1, 0);
      seq_len   = 4'd2;
      seq_start = 1'b1;
      tick();
      seq_start = 1'b0;
      load_arm(0);
      wr_entry(1, 30'h1555_0000, 30'h2AAA_0000, 30'h0033_0000, 2, 0);
      play_passes(0);
      tick();
      load_arm(1);
      play_passes(1);
      tick();
      chk("rewrite_done", 64'(seq_done), 64'd1);
      tick();

      // Asynchronous reset in the middle of RUN
      wr_entry(0, 30'h0777_0000, 30'h0888_0000, 30'h0009_0000, 3, 0);
      seq_len   = 4'd1;
      seq_start = 1'b1;
      tick();
      seq_start = 1'b0;
      load_arm(0);
      ch_wrap = 1'b1;
      tick();
      ch_wrap = 1'b0;
      #2 rstn = 1'b0;
      #1;
      chk_idle("arst");
      chk("arst_seg",  64'(seq_seg),  64'd0);
      chk("arst_done", 64'(seq_done), 64'd0);
      chk("arst_ofs",  64'(set_ofs),  64'd0);
      chk("arst_size", 64'(set_size), 64'd0);
      chk("arst_step", 64'(set_step), 64'd0);
      tick();
      rstn = 1'b1;
      tick();
      for (int i = 0; i < NSEG; i++) begin
         m_ofs[i] = '0; m_size[i] = '0; m_step[i] = '0; m_npass[i] = 0; m_dwell[i] = 0;
      end
      run_seq(1, 1'b0, 1);    // cleared entry: zero config, single pass

`ifdef ASG_SEQ_DWELL_EN
      // 2 us dwell after entry 0, none after the final entry
      wr_entry(0, 30'h0000_1111, 30'h0000_2222, 30'h0000_0001, 1, 2);
      wr_entry(1, 30'h0000_3333, 30'h0000_4444, 30'h0000_0002, 1, 3);
      run_seq(2, 1'b0, 2);
`endif

      // Randomised tables, lengths and loop mode
      for (int r = 0; r < 6; r++) begin
         int len;
         bit lp;
         for (int i = 0; i < NSEG; i++) begin
            wr_entry(i, PW'($urandom), PW'($urandom), PW'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 1));
         end
         len = $urandom_range(1, NSEG);
         lp  = 1'($urandom_range(0, 1));
         run_seq(len, lp, lp ? len + $urandom_range(1, len) : len);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/red_pitaya_asg_seq.md
# red_pitaya_asg_seq

Segment sequencer for one ASG channel. It holds a small table of waveform segments, each with its own buffer offset, size, step and pass count, and plays them back to back. For each segment it drives the channel's configuration, reset and software-trigger inputs, then counts the channel's end-of-table pulses to decide when to advance. One instance sits beside each ASG channel in the `dac_clk_i` domain, between the bus register bank and the channel.

## Interface
- `RSZ`, 14: buffer address width; pointer fields are RSZ+16 bits (16 fractional).
- `NSEG`, 8: number of segment entries; a power of two, 2..16.
- `SW`, 3: log2(NSEG).

Ports (clock and reset first):
- `dac_clk_i`  in  1  DAC clock; one clock.
- `dac_rstn_i`  in  1  reset, asynchronous, active-low.
- `tbl_we_i`  in  1  table write strobe; writes one full entry.
- `tbl_seg_i`  in  SW  entry index to write.
- `tbl_ofs_i`  in  RSZ+16  segment start pointer.
- `tbl_size_i`  in  RSZ+16  segment end pointer (table size).
- `tbl_step_i`  in  RSZ+16  pointer step.
- `tbl_npass_i`  in  16  passes per segment; 0 is treated as 1.
- `seq_len_i`  in  SW+1  active entries, 1..NSEG; values 0 or >NSEG make start ignored.
- `seq_loop_i`  in  1  restart at entry 0 after the last entry.
- `seq_start_i`  in  1  start pulse.
- `seq_stop_i`  in  1  abort pulse.
- `ch_wrap_i`  in  1  channel end-of-table pulse (channel trig_done).
- `set_ofs_o`, `set_size_o`, `set_step_o`  out  RSZ+16  channel configuration; reset 0.
- `set_rst_o`  out  1  channel FSM reset; reset 1.
- `trig_sw_o`  out  1  channel software trigger; reset 0.
- `seq_busy_o`  out  1  high in any state except IDLE; reset 0.
- `seq_seg_o`  out  SW  current entry index; reset 0.
- `seq_done_o`  out  1  one-cycle pulse on natural completion; reset 0.

## Operation
- States: IDLE, LOAD, ARM, RUN, NEXT (plus DWELL, see Configuration).
- IDLE: `set_rst_o`=1. When `seq_start_i` arrives with a valid `seq_len_i`, set seg=0 and go to LOAD.
- LOAD (1 cycle): configuration outputs register the table entry `seg` as it was before the entering edge; `set_rst_o`=1; pass counter cleared. Go to ARM.
- ARM (1 cycle): `set_rst_o`=0, `trig_sw_o`=1. Go to RUN.
- RUN: each `ch_wrap_i` increments the 16-bit pass counter. When the count reaches max(npass,1), go to NEXT.
- NEXT (1 cycle):
  - If seg < len-1: seg+1, go to LOAD.
  - Else if `seq_loop_i`: seg=0, go to LOAD.
  - Else: go to IDLE and pulse `seq_done_o`.
- `seq_stop_i` forces IDLE on the next edge from any state, with `set_rst_o`=1 and no `seq_done_o`.
- Stop and start in the same cycle: stop wins.
- Start while busy is ignored.
- `ch_wrap_i` is ignored outside RUN.
- Table writes are accepted in any state. They take effect only when an entry is next loaded. A write on the same edge as entry into LOAD is not seen by that load.
- `seq_len_i` and `seq_loop_i` are sampled in NEXT. Changing them mid-run is legal.
- Async reset mid-run: all outputs return to reset values immediately; table contents are cleared to 0.

## Timing
- Start to `trig_sw_o` high: 2 cycles (IDLE→LOAD→ARM).
- Configuration is stable 1 cycle before `set_rst_o` falls.
- The final `ch_wrap_i` of a segment to the next segment's `trig_sw_o`: 3 cycles (RUN→NEXT→LOAD→ARM).
- All outputs are registered.

## Configuration
- `ASG_SEQ_DWELL_EN` defined:
  - Adds input `tbl_dwell_i` [16] to each entry and a DWELL state between NEXT and LOAD.
  - DWELL holds `set_rst_o`=1 for dwell × 1 µs, using a 125-cycle tick.
  - A dwell of 0 skips the state.
  - No dwell is applied after the final entry.
- Undefined: the port and state are absent; NEXT goes directly to LOAD.

## Structure
- Package `red_pitaya_asg_seq_pkg`: state enum, segment-entry struct (ofs/size/step/npass[/dwell]), `TICK_DIV`=125.
- Sub-module `red_pitaya_asg_seq_tbl`: NSEG-entry register file with async clear, one write port and one registered read port.

## Test plan
- len=1, npass=3, ofs=0, size=0x3FFF_FFFF, start → `trig_sw_o` at cycle +2; after the 3rd `ch_wrap_i`, `seq_done_o` pulses 1 cycle later and `set_rst_o`=1.
- len=3, npass 1/2/0, loop=0 → `seq_seg_o` steps 0,1,2; 4 wraps total; config outputs match each entry in LOAD.
- loop=1, len=2 → after entry 1, `seq_seg_o` returns to 0 with no `seq_done_o`; stop → IDLE next edge, no done.
- Start and stop in the same cycle; start while busy; `seq_len_i`=0 → no state change in any case.
- Rewrite entry 1 during RUN of entry 0 → the new values appear at entry 1's LOAD; `dac_rstn_i` low mid-RUN → all outputs at reset values immediately.
- With `ASG_SEQ_DWELL_EN`, dwell=2 → 250 cycles of `set_rst_o`=1 between segments.
